// File: rtl/rx_fifo_pkg.sv
// Shared types for the UART receive FIFO: drain FSM states and the stored entry.
// Entry layout follows RX_FIFO_ERR_TAG_EN (error flags stored only when defined).
package rx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } rx_state_e;

`ifdef RX_FIFO_ERR_TAG_EN
  typedef struct packed {
    logic       ferr;
    logic       oerr;
    logic [7:0] data;
  } rx_entry_t;
`else
  typedef struct packed {
    logic [7:0] data;
  } rx_entry_t;
`endif

  localparam int ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH-entry register array: one write port, combinational read, cleared on reset.
module rx_fifo_mem
  import rx_fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  rx_entry_t         wdata,
  input  logic [ADDR_W-1:0] raddr,
  output rx_entry_t         rdata
);

  rx_entry_t mem_q [DEPTH];
  rx_entry_t mem_d [DEPTH];

  // next-state of the array
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d[waddr] = mem_q[waddr];
    end
  end

  // storage flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_fifo.sv
// Receive-side byte FIFO draining a UART receive buffer via data_ready/data_read.
// Define RX_FIFO_ERR_TAG_EN to store and present per-byte framing/overrun flags.
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             data_ready,
  input  logic             overrun_error,
  input  logic             framing_error,
  output logic             data_read,
  input  logic             pop,
  output logic [7:0]       rd_data,
  output logic             rd_ferr,
  output logic             rd_oerr,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             underflow,
  input  logic             clear_flags
);

  localparam int ADDR_W = $clog2(DEPTH);

  rx_state_e         state_q;
  logic              data_read_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              underflow_q, underflow_d;
  logic              push_s, pop_ok_s, full_s, empty_s;
  rx_entry_t         wr_entry_s, head_s;

  assign full_s   = (count_q == CNT_W'(DEPTH));
  assign empty_s  = (count_q == {CNT_W{1'b0}});
  // a pop this cycle never frees a slot for a push this cycle
  assign push_s   = (state_q == IDLE) && data_ready && !full_s;
  assign pop_ok_s = pop && !empty_s;

  // assemble the entry to store
  always_comb begin
    wr_entry_s      = '0;
    wr_entry_s.data = rx_data;
`ifdef RX_FIFO_ERR_TAG_EN
    wr_entry_s.ferr = framing_error;
    wr_entry_s.oerr = overrun_error;
`endif
  end

  // drain handshake; SETTLE ignores data_ready while the receiver drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_read_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push_s) begin
            state_q     <= ACK;
            data_read_q <= 1'b1;
          end else begin
            state_q     <= IDLE;
            data_read_q <= 1'b0;
          end
        end
        ACK: begin
          state_q     <= SETTLE;
          data_read_q <= 1'b0;
        end
        SETTLE: begin
          state_q     <= IDLE;
          data_read_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          data_read_q <= 1'b0;
        end
      endcase
    end
  end

  // pointers, occupancy and sticky underflow
  always_comb begin
    wr_ptr_d = push_s   ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_s ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    case ({push_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (pop && empty_s) begin
      underflow_d = 1'b1;
    end else if (clear_flags) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // datapath state flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_s),
    .waddr (wr_ptr_q),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_q),
    .rdata (head_s)
  );

  assign data_read = data_read_q;
  assign rd_data   = head_s.data;
  assign empty     = empty_s;
  assign full      = full_s;
  assign count     = count_q;
  assign underflow = underflow_q;

`ifdef RX_FIFO_ERR_TAG_EN
  assign rd_ferr = head_s.ferr;
  assign rd_oerr = head_s.oerr;
`else
  logic unused_err_s;
  assign unused_err_s = framing_error ^ overrun_error;
  assign rd_ferr = 1'b0;
  assign rd_oerr = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo with a byte-order scoreboard queue.
module tb_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       data_read;
  logic       pop;
  logic [7:0] rd_data;
  logic       rd_ferr;
  logic       rd_oerr;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       underflow;
  logic       clear_flags;

  int         total = 0;
  int         bad = 0;
  int         exp_count = 0;
  logic [7:0] sb_q[$];

  rx_fifo #(.DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .data_read     (data_read),
    .pop           (pop),
    .rd_data       (rd_data),
    .rd_ferr       (rd_ferr),
    .rd_oerr       (rd_oerr),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .underflow     (underflow),
    .clear_flags   (clear_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // waits for data_ready acknowledge, bounded; returns negedges waited
  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (data_read !== 1'b1 && cyc < 40);
  endtask

  task automatic send(input logic [7:0] b, input logic fe, input logic oe);
    int cyc;
    rx_data = b;
    framing_error = fe;
    overrun_error = oe;
    data_ready = 1'b1;
    sb_q.push_back(b);
    wait_ack(cyc);
    chk("ack_latency", cyc, 1);
    exp_count++;
    chk("count_after_push", count, exp_count);
    data_ready = 1'b0;
    @(negedge clk);
    chk("ack_single_pulse", data_read, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_pop();
    chk("pop_head", rd_data, sb_q[0]);
    void'(sb_q.pop_front());
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    exp_count--;
    chk("count_after_pop", count, exp_count);
  endtask

  initial begin
    int cyc;
    int nack;
    rst = 1'b1;
    rx_data = 8'h00;
    data_ready = 1'b0;
    overrun_error = 1'b0;
    framing_error = 1'b0;
    pop = 1'b0;
    clear_flags = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_data_read", data_read, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);

    // 1: single byte
    send(8'hA5, 1'b0, 1'b0);
    chk("t1_rd_data", rd_data, 8'hA5);
    chk("t1_empty", empty, 1'b0);
    do_pop();
    chk("t1_empty_after_pop", empty, 1'b1);

    // 2: fill, then a blocked ninth byte released by one pop
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b0);
    chk("t2_full", full, 1'b1);
    chk("t2_count", count, 8);
    rx_data = 8'h09;
    data_ready = 1'b1;
    sb_q.push_back(8'h09);
    nack = 0;
    repeat (6) begin
      @(negedge clk);
      if (data_read === 1'b1) nack++;
    end
    chk("t2_no_ack_when_full", nack, 0);
    chk("t2_count_held", count, 8);
    do_pop();
    wait_ack(cyc);
    chk("t2_ack_after_pop", cyc, 1);
    exp_count++;
    data_ready = 1'b0;
    chk("t2_count_refill", count, exp_count);
    chk("t2_head", rd_data, 8'h02);
    repeat (2) @(negedge clk);

    // 3: pointer wrap
    repeat (3) do_pop();
    send(8'h0A, 1'b0, 1'b0);
    send(8'h0B, 1'b0, 1'b0);
    send(8'h0C, 1'b0, 1'b0);
    chk("t3_full", full, 1'b1);
    repeat (4) do_pop();

    // 4: simultaneous push and pop at count 4
    chk("t4_count_before", count, 4);
    chk("t4_head_before", rd_data, sb_q[0]);
    void'(sb_q.pop_front());
    sb_q.push_back(8'h0D);
    rx_data = 8'h0D;
    data_ready = 1'b1;
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    chk("t4_ack", data_read, 1'b1);
    chk("t4_count_same", count, 4);
    chk("t4_head_advanced", rd_data, sb_q[0]);
    data_ready = 1'b0;
    repeat (2) @(negedge clk);
    repeat (4) do_pop();
    chk("t4_drained_empty", empty, 1'b1);

    // 5: underflow flag
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    chk("t5_underflow_set", underflow, 1'b1);
    chk("t5_count_zero", count, 0);
    repeat (2) @(negedge clk);
    chk("t5_underflow_sticky", underflow, 1'b1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("t5_underflow_cleared", underflow, 1'b0);
    pop = 1'b1;
    clear_flags = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    clear_flags = 1'b0;
    chk("t5_set_wins", underflow, 1'b1);

    // 6: error tagging and reset mid-handshake
    send(8'h3C, 1'b1, 1'b0);
    send(8'h3D, 1'b0, 1'b1);
`ifdef RX_FIFO_ERR_TAG_EN
    chk("t6_ferr_head", rd_ferr, 1'b1);
    chk("t6_oerr_head", rd_oerr, 1'b0);
    do_pop();
    chk("t6_ferr_next", rd_ferr, 1'b0);
    chk("t6_oerr_next", rd_oerr, 1'b1);
`else
    chk("t6_ferr_tied", rd_ferr, 1'b0);
    chk("t6_oerr_tied", rd_oerr, 1'b0);
`endif
    rx_data = 8'h77;
    framing_error = 1'b0;
    overrun_error = 1'b0;
    data_ready = 1'b1;
    wait_ack(cyc);
    chk("t6_ack_before_rst", data_read, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_data_read", data_read, 1'b0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1'b1);
    chk("t6_rst_rd_data", rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    sb_q.push_back(8'h77);
    exp_count = 0;
    wait_ack(cyc);
    chk("t6_recapture_latency", cyc, 1);
    data_ready = 1'b0;
    exp_count++;
    chk("t6_recapture_count", count, exp_count);
    chk("t6_recapture_data", rd_data, sb_q[0]);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
